synch_updown_count_n: RTL



---
 rtl/synch_updown_count_n.sv | 116 +++++++++++
 1 files changed

// File: rtl/synch_updown_count_n.sv
`default_nettype none
// ============================================================================
// Module      : synch_updown_count_n
// Description : Parametrised synchronous up/down modulo counter with count
//               enable, saturating parallel load, combinational terminal
//               count (for cascading) and a registered wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module synch_updown_count_n #(
  parameter int WIDTH   = 4,
  parameter int MOD     = 16,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  // Terminal value truncated to WIDTH bits; with MOD == 2^WIDTH this is
  // all-ones and wrapping matches natural binary overflow.
  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] C_RST = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  // Refuse to elaborate with an illegal modulus or reset value.
  generate
    if (MOD < 2 || MOD > (1 << WIDTH) || RST_VAL < 0 || RST_VAL >= MOD) begin : g_bad_params
      $fatal(1, "synch_updown_count_n: illegal MOD/RST_VAL for WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_over;
  logic             w_d_over;

  // Range decodes; compares done as int so MOD == 2^WIDTH needs no special case.
  always_comb begin
    w_at_max  = (count_q == C_MAX);
    w_at_zero = (count_q == '0);
    w_over    = (int'(count_q) >= MOD);
    w_d_over  = (int'(d) >= MOD);
  end

  // Next-state selection in priority order load > en > hold (rst handled in the register).
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = w_d_over ? C_MAX : d;
    end else if (en) begin
      if (up_dn) begin
        if (w_at_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else if (w_over) begin
          // Out-of-range recovery: snap back to zero without signalling a wrap.
          count_d = '0;
        end else begin
          count_d = count_q + C_ONE;
        end
      end else begin
        if (w_at_zero) begin
          count_d = C_MAX;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - C_ONE;
        end
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= C_RST;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Terminal count is purely combinational so a cascaded stage sees it in the same cycle.
  always_comb begin
    tc = en & ((up_dn & w_at_max) | (~up_dn & w_at_zero));
  end

  assign q    = count_q;
  assign qbar = ~count_q;
  assign wrap = wrap_q;

`ifndef SYNTHESIS
  // The count register should never hold a value at or beyond the modulus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!w_over)
        else $error("synch_updown_count_n: count out of range");
    end
  end
`endif

endmodule
`default_nettype wire
